// File: rtl/somador_acumulador_param_if.sv
// Sample-in / result-out bundle of the parametrised signed accumulator.
// The master side feeds samples and starts runs; the slave side is the accumulator.
interface somador_acumulador_param_if #(
  parameter int unsigned WIDTH = 6
);
  logic                    inicio;
  logic                    valor_valid;
  logic signed [WIDTH-1:0] valor;
  logic                    pronto;
  logic                    busy;
  logic signed [WIDTH-1:0] soma;
  logic                    soma_valid;
  logic                    overflow;

  modport master (
    output inicio, valor_valid, valor,
    input  pronto, busy, soma, soma_valid, overflow
  );

  modport slave (
    input  inicio, valor_valid, valor,
    output pronto, busy, soma, soma_valid, overflow
  );
endinterface

// File: rtl/somador_acumulador_param.sv
// Signed accumulator: after a start it sums N_SAMPLES qualified samples, then
// publishes the result with a one-cycle strobe and a sticky per-run overflow flag.
module somador_acumulador_param #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  somador_acumulador_param_if.slave     bus
);
  localparam int unsigned CW = $clog2(N_SAMPLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] soma_q, soma_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    valid_q, valid_d;
  logic signed [WIDTH-1:0] raw;
  logic signed [WIDTH-1:0] sum;
  logic                    ovf_step;

  // Adder with signed overflow detection and optional clamping
  always_comb begin
    raw      = acc_q + bus.valor;
    ovf_step = (acc_q[WIDTH-1] == bus.valor[WIDTH-1]) && (raw[WIDTH-1] != acc_q[WIDTH-1]);
    sum      = raw;
    if ((SATURATE != 0) && ovf_step) begin
      sum = acc_q[WIDTH-1] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      soma_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      soma_q  <= soma_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: a start from IDLE or DONE clears the run; DONE is a single cycle
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    soma_d  = soma_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.inicio) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (bus.valor_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | ovf_step;
          if (count_q == LAST_IDX) begin
            soma_d  = sum;
            valid_d = 1'b1;
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pronto     = (state_q != ACCUM);
  assign bus.busy       = (state_q == ACCUM);
  assign bus.soma       = soma_q;
  assign bus.soma_valid = valid_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_somador_acumulador_param.sv
// Bench for somador_acumulador_param: wrap, saturating and single-sample
// instances fed from shared sample lines, checked against a reference model.
module tb_somador_acumulador_param;
  localparam int MAXV = 31;
  localparam int MINV = -32;

  typedef struct packed {
    logic signed [5:0] soma;
    logic              ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              inicio_a = 1'b0;
  logic              inicio_b = 1'b0;
  logic              valor_valid = 1'b0;
  logic signed [5:0] valor = '0;

  int errors = 0;
  int checks = 0;
  int vcnt_w = 0;
  int vcnt_s = 0;
  int vcnt_1 = 0;

  exp_t q_w[$];
  exp_t q_s[$];
  exp_t q_1[$];

  somador_acumulador_param_if #(.WIDTH(6)) bus_w ();
  somador_acumulador_param_if #(.WIDTH(6)) bus_s ();
  somador_acumulador_param_if #(.WIDTH(6)) bus_1 ();

  assign bus_w.inicio = inicio_a;
  assign bus_s.inicio = inicio_a;
  assign bus_1.inicio = inicio_b;
  assign bus_w.valor_valid = valor_valid;
  assign bus_s.valor_valid = valor_valid;
  assign bus_1.valor_valid = valor_valid;
  assign bus_w.valor = valor;
  assign bus_s.valor = valor;
  assign bus_1.valor = valor;

  somador_acumulador_param #(.WIDTH(6), .N_SAMPLES(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w));
  somador_acumulador_param #(.WIDTH(6), .N_SAMPLES(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s));
  somador_acumulador_param #(.WIDTH(6), .N_SAMPLES(1), .SATURATE(0)) dut_1 (
    .clk(clk), .reset(reset), .bus(bus_1));

  always #5 clk = ~clk;

  // Reference: exact integer sum per step, then wrap or clamp into 6 bits
  function automatic exp_t model(input int s0, input int s1, input int s2, input int s3,
                                 input int n, input bit sat);
    int   s[4];
    int   acc;
    int   t;
    exp_t e;
    s   = '{s0, s1, s2, s3};
    acc = 0;
    e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = acc + s[i];
      if (t > MAXV || t < MINV) begin
        e.ovf = 1'b1;
        if (sat) t = (t > MAXV) ? MAXV : MINV;
        else     t = (t > MAXV) ? t - 64 : t + 64;
      end
      acc = t;
    end
    e.soma = 6'(acc);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int s0, input int s1, input int s2, input int s3);
    q_w.push_back(model(s0, s1, s2, s3, 4, 1'b0));
    q_s.push_back(model(s0, s1, s2, s3, 4, 1'b1));
  endtask

  task automatic start_a();
    inicio_a = 1'b1;
    tick();
    inicio_a = 1'b0;
  endtask

  // Feeds four samples; returns #1 after the edge that accepts the last one
  task automatic feed(input int s0, input int s1, input int s2, input int s3,
                      input int gap, input bit poke);
    int s[4];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      valor = 6'(s[i]);
      valor_valid = 1'b1;
      tick();
      valor_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          valor    = 6'sd25;
          inicio_a = poke;
          checks++;
          if (bus_w.busy !== 1'b1 || bus_w.pronto !== 1'b0) begin
            errors++;
            $display("FAIL gap_busy: busy=%b pronto=%b, required busy=1 pronto=0", bus_w.busy, bus_w.pronto);
          end
          tick();
          inicio_a = 1'b0;
        end
      end
    end
  endtask

  // Scoreboard monitors: every strobe must match the oldest queued expectation
  always @(posedge clk) begin : mon_w
    exp_t e;
    #1;
    if (bus_w.soma_valid === 1'b1) begin
      vcnt_w++;
      checks++;
      if (q_w.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_w: soma=%0d, required no strobe", $signed(bus_w.soma));
      end else begin
        e = q_w.pop_front();
        if (bus_w.soma !== e.soma || bus_w.overflow !== e.ovf) begin
          errors++;
          $display("FAIL result_w: soma=%0d ovf=%b, required soma=%0d ovf=%b",
                   $signed(bus_w.soma), bus_w.overflow, $signed(e.soma), e.ovf);
        end
      end
    end
  end

  always @(posedge clk) begin : mon_s
    exp_t e;
    #1;
    if (bus_s.soma_valid === 1'b1) begin
      vcnt_s++;
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_s: soma=%0d, required no strobe", $signed(bus_s.soma));
      end else begin
        e = q_s.pop_front();
        if (bus_s.soma !== e.soma || bus_s.overflow !== e.ovf) begin
          errors++;
          $display("FAIL result_s: soma=%0d ovf=%b, required soma=%0d ovf=%b",
                   $signed(bus_s.soma), bus_s.overflow, $signed(e.soma), e.ovf);
        end
      end
    end
  end

  always @(posedge clk) begin : mon_1
    exp_t e;
    #1;
    if (bus_1.soma_valid === 1'b1) begin
      vcnt_1++;
      checks++;
      if (q_1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_1: soma=%0d, required no strobe", $signed(bus_1.soma));
      end else begin
        e = q_1.pop_front();
        if (bus_1.soma !== e.soma || bus_1.overflow !== e.ovf) begin
          errors++;
          $display("FAIL result_1: soma=%0d ovf=%b, required soma=%0d ovf=%b",
                   $signed(bus_1.soma), bus_1.overflow, $signed(e.soma), e.ovf);
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    checks++;
    if (bus_w.soma !== 6'sd0 || bus_w.soma_valid !== 1'b0 || bus_w.overflow !== 1'b0 ||
        bus_w.pronto !== 1'b1 || bus_w.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: soma=%0d valid=%b ovf=%b pronto=%b busy=%b, required 0 0 0 1 0",
               $signed(bus_w.soma), bus_w.soma_valid, bus_w.overflow, bus_w.pronto, bus_w.busy);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int v0;
    v0 = vcnt_w;
    push_a(3, 5, -2, 7);
    start_a();
    checks++;
    if (bus_w.busy !== 1'b1 || bus_w.pronto !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: busy=%b pronto=%b, required 1 0", bus_w.busy, bus_w.pronto);
    end
    feed(3, 5, -2, 7, 0, 1'b0);
    checks++;
    if (bus_w.soma_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: soma_valid=%b one cycle after 4th sample, required 1", bus_w.soma_valid);
    end
    tick();
    checks++;
    if (bus_w.soma_valid !== 1'b0 || bus_w.pronto !== 1'b1 || vcnt_w - v0 != 1) begin
      errors++;
      $display("FAIL strobe_width: valid=%b pronto=%b strobes=%0d, required 0 1 1",
               bus_w.soma_valid, bus_w.pronto, vcnt_w - v0);
    end
  endtask

  task automatic test_overflow();
    push_a(20, 20, 0, 0);
    start_a();
    feed(20, 20, 0, 0, 0, 1'b0);
    tick();
    push_a(20, 20, -20, 0);
    start_a();
    feed(20, 20, -20, 0, 0, 1'b0);
    tick();
    checks++;
    if (bus_w.overflow !== 1'b1 || bus_w.soma !== 6'sd20) begin
      errors++;
      $display("FAIL sticky_hold: soma=%0d ovf=%b in IDLE, required 20 1", $signed(bus_w.soma), bus_w.overflow);
    end
    push_a(-30, -10, 0, 0);
    start_a();
    checks++;
    if (bus_w.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_on_start: ovf=%b, required 0", bus_w.overflow);
    end
    feed(-30, -10, 0, 0, 0, 1'b0);
    tick();
    push_a(1, 1, 1, 1);
    start_a();
    feed(1, 1, 1, 1, 0, 1'b0);
    tick();
  endtask

  task automatic test_gaps();
    int v0;
    v0 = vcnt_w;
    push_a(1, 2, 3, 4);
    start_a();
    feed(1, 2, 3, 4, 2, 1'b1);
    tick();
    checks++;
    if (vcnt_w - v0 != 1 || bus_w.soma !== 6'sd10) begin
      errors++;
      $display("FAIL gaps_run: strobes=%0d soma=%0d, required 1 10", vcnt_w - v0, $signed(bus_w.soma));
    end
  endtask

  task automatic test_reset_midrun();
    int v0;
    v0 = vcnt_w;
    start_a();
    valor = 6'sd9;
    valor_valid = 1'b1;
    tick();
    tick();
    valor_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (bus_w.soma !== 6'sd0 || bus_w.pronto !== 1'b1 || bus_w.busy !== 1'b0 ||
        bus_w.overflow !== 1'b0 || bus_w.soma_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: soma=%0d pronto=%b busy=%b ovf=%b valid=%b, required 0 1 0 0 0",
               $signed(bus_w.soma), bus_w.pronto, bus_w.busy, bus_w.overflow, bus_w.soma_valid);
    end
    tick();
    reset = 1'b0;
    valor = 6'sd9;
    valor_valid = 1'b1;
    tick();
    tick();
    valor_valid = 1'b0;
    checks++;
    if (vcnt_w != v0 || bus_w.busy !== 1'b0) begin
      errors++;
      $display("FAIL aborted_run: strobes=%0d busy=%b, required 0 0", vcnt_w - v0, bus_w.busy);
    end
    push_a(2, 2, 2, 2);
    start_a();
    feed(2, 2, 2, 2, 0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    push_a(5, 5, 5, 5);
    push_a(-1, -2, -3, -4);
    start_a();
    feed(5, 5, 5, 5, 0, 1'b0);
    inicio_a = 1'b1;
    tick();
    inicio_a = 1'b0;
    checks++;
    if (bus_w.busy !== 1'b1 || bus_w.overflow !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: busy=%b ovf=%b after DONE+inicio, required 1 0", bus_w.busy, bus_w.overflow);
    end
    feed(-1, -2, -3, -4, 0, 1'b0);
    tick();
  endtask

  task automatic test_single();
    q_1.push_back(model(-5, 0, 0, 0, 1, 1'b0));
    inicio_b = 1'b1;
    tick();
    inicio_b = 1'b0;
    valor = -6'sd5;
    valor_valid = 1'b1;
    tick();
    valor_valid = 1'b0;
    checks++;
    if (bus_1.soma_valid !== 1'b1 || bus_1.soma !== -6'sd5 || bus_1.overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_sample: valid=%b soma=%0d ovf=%b, required 1 -5 0",
               bus_1.soma_valid, $signed(bus_1.soma), bus_1.overflow);
    end
    tick();
    checks++;
    if (bus_1.soma_valid !== 1'b0 || bus_1.pronto !== 1'b1) begin
      errors++;
      $display("FAIL single_done: valid=%b pronto=%b, required 0 1", bus_1.soma_valid, bus_1.pronto);
    end
  endtask

  task automatic test_drain();
    tick();
    tick();
    checks++;
    if (q_w.size() != 0 || q_s.size() != 0 || q_1.size() != 0) begin
      errors++;
      $display("FAIL drain: pending w=%0d s=%0d n1=%0d, required 0 0 0", q_w.size(), q_s.size(), q_1.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_gaps();
    test_reset_midrun();
    test_back_to_back();
    test_single();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/somador_acumulador_param.md
Name: somador_acumulador_param

Overview:
Parametrised signed sample accumulator. It is the successor of the fixed 6-bit, four-add summing FSM.
- After a start command, it sums N_SAMPLES qualified two's-complement samples.
- It then publishes the result with a one-cycle valid strobe and a per-run sticky overflow flag.
- Optional saturating arithmetic is available.
- It sits between the sample source and the result consumer in the summation datapath.

Parameters:
WIDTH, 6, bit width of the samples, accumulator and result (two's complement, >=2).
N_SAMPLES, 4, number of accepted samples per run (>=1).
SATURATE, 0, 0 = wrap on overflow; 1 = clamp to the signed max/min of WIDTH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
inicio  input  1  start request; sampled only while pronto=1.
valor_valid  input  1  qualifies valor; a sample is accepted on a rising edge when the FSM is in ACCUM and valor_valid=1.
valor  input  WIDTH  signed sample.
pronto  output  1  block idle/ready to accept inicio.
busy  output  1  run in progress (equal to state==ACCUM).
soma  output  WIDTH  signed result of the last completed run; holds until the next completion.
soma_valid  output  1  one-cycle strobe: soma has just been updated.
overflow  output  1  sticky: at least one addition in the current/last run overflowed.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
  - Reset values: state=IDLE, acc=0, count=0, soma=0, soma_valid=0, overflow=0, pronto=1, busy=0.
- States: IDLE, ACCUM, DONE. pronto=1 in IDLE and DONE; busy=1 only in ACCUM.
- IDLE:
  - inicio=1 -> ACCUM, with acc<=0, count<=0, overflow<=0.
  - Otherwise the FSM stays in IDLE. soma and overflow keep their last values.
- ACCUM, on each edge with valor_valid=1:
  - acc<=sum and count<=count+1.
  - If count==N_SAMPLES-1, also soma<=sum and state<=DONE.
- ACCUM with valor_valid=0: no change; no timeout.
- inicio is ignored in ACCUM.
- DONE lasts exactly one cycle with soma_valid=1.
  - inicio=1 in DONE -> ACCUM, cleared exactly as from IDLE (back-to-back runs).
  - Otherwise DONE -> IDLE.
- Latency: soma_valid rises in the cycle after the edge that accepts the N_SAMPLES-th sample.
- Arithmetic: raw = acc + valor, evaluated in WIDTH bits, signed.
  - ovf_step = (acc[MSB]==valor[MSB]) && (raw[MSB]!=acc[MSB]).
  - SATURATE=0: sum=raw (wrap).
  - SATURATE=1 with ovf_step: sum = +2^(WIDTH-1)-1 if acc is non-negative, else -2^(WIDTH-1).
  - SATURATE=1 without ovf_step: sum=raw.
  - Any accepted sample with ovf_step=1 sets overflow.
  - overflow stays set until the next run start or reset. It is not cleared when a later addition brings the value back in range.
- N_SAMPLES=1: the first accepted sample goes directly to DONE; soma = that sample; overflow=0.
- count width = clog2(N_SAMPLES+1); count never exceeds N_SAMPLES-1.
- Reset asserted mid-run: the run is aborted immediately and all outputs take their reset values. No soma_valid is produced for the aborted run.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=6, N=4, SAT=0:
   - Stimulus: inicio pulse, then valor=3,5,-2,7 with valid each cycle.
   - Required response: soma=13, overflow=0, soma_valid high exactly one cycle, 1 cycle after the 4th sample; pronto returns high.
2. Positive overflow, valor=20,20,0,0:
   - SAT=0 -> soma=-24, overflow=1.
   - SAT=1 -> soma=31, overflow=1.
   - SAT=0 with 20,20,-20,0 -> soma=20, overflow still 1 (sticky).
3. Negative overflow, valor=-30,-10,0,0:
   - SAT=0 -> soma=24, overflow=1.
   - SAT=1 -> soma=-32, overflow=1.
   - A following clean run 1,1,1,1 -> soma=4, overflow=0.
4. Gaps and ignored start:
   - Stimulus: samples 1,2,3,4 with valor_valid low for 2 cycles between each; inicio pulsed during ACCUM.
   - Required response: soma=10, the run does not restart, busy stays high throughout.
5. Reset mid-run:
   - Stimulus: assert reset after the 2nd sample; after release, run 2,2,2,2.
   - Required response: no soma_valid during the aborted run; soma=0 and pronto=1 during reset; the new run gives soma=8.
6. Back-to-back and N=1:
   - inicio held high in DONE -> the new run starts with no IDLE cycle.
   - N_SAMPLES=1 with valor=-5 -> soma=-5 one cycle after acceptance.
